mat_stream_ctrl: RTL and testbench

Command-driven sequencer that moves whole vectors between a valid/ready vector stream and the matrix register. It drives the matrix register's write port (LOAD) and read port (STORE), and is the producer/consumer counterpart of that register. LOAD issues one row or column write per accepted input beat. STORE walks row or column reads onto an output stream with backpressure. It sits between the matrix unit's vector bus and one matrix register instance.

---
 rtl/MatPkg.sv | 36 +++
 rtl/mat_stream_index_counter.sv | 51 +++++
 rtl/mat_stream_ctrl.sv | 158 +++++++++++++++
 tb/tb_mat_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/MatPkg.sv
// Shared matrix-unit types: register read/write opcodes plus the stream
// sequencer command and state encodings.
package MatPkg;

    typedef enum logic [0:0] {
        MAT_DATA_READ_ROW = 1'b0,
        MAT_DATA_READ_COL = 1'b1
    } MatDataReadOp_t;

    typedef enum logic [1:0] {
        MAT_DATA_WRITE_DISABLE   = 2'd0,
        MAT_DATA_WRITE_ROW       = 2'd1,
        MAT_DATA_WRITE_COL       = 2'd2,
        MAT_DATA_WRITE_TRANSPOSE = 2'd3
    } MatDataWriteOp_t;

    typedef enum logic [1:0] {
        LOAD_ROWS  = 2'd0,
        LOAD_COLS  = 2'd1,
        STORE_ROWS = 2'd2,
        STORE_COLS = 2'd3
    } MatStreamOp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        XPOSE = 3'd3,
        DONE  = 3'd4
    } MatStreamState_t;

    function automatic logic is_load(input MatStreamOp_t op);
        return (op == LOAD_ROWS) || (op == LOAD_COLS);
    endfunction

endpackage

// File: rtl/mat_stream_index_counter.sv
// Beat counter for mat_stream_ctrl: holds base/count/k and produces the
// wrapped row/column index (base + k) mod WIDTH and a last-beat flag.
module mat_stream_index_counter #(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH_ADDR_SIZE-1:0] start_base,
    input  logic [WIDTH_ADDR_SIZE:0]   start_count,
    input  logic                       step,
    output logic [WIDTH_ADDR_SIZE-1:0] idx,
    output logic                       last
);
    localparam logic [WIDTH_ADDR_SIZE:0] WIDTH_W = (WIDTH_ADDR_SIZE+1)'(WIDTH);

    logic [WIDTH_ADDR_SIZE-1:0] base_r;
    logic [WIDTH_ADDR_SIZE:0]   count_r;
    logic [WIDTH_ADDR_SIZE:0]   k_r;
    logic [WIDTH_ADDR_SIZE:0]   sum_s;

    // Command latch and beat advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_r  <= '0;
            count_r <= '0;
            k_r     <= '0;
        end else if (start) begin
            base_r  <= start_base;
            count_r <= start_count;
            k_r     <= '0;
        end else if (step) begin
            k_r     <= k_r + (WIDTH_ADDR_SIZE+1)'(1);
        end else begin
            k_r     <= k_r;
        end
    end

    // base and k are both below WIDTH, so a single subtraction wraps the sum.
    always_comb begin
        sum_s = {1'b0, base_r} + k_r;
        if (sum_s >= WIDTH_W) begin
            idx = WIDTH_ADDR_SIZE'(sum_s - WIDTH_W);
        end else begin
            idx = WIDTH_ADDR_SIZE'(sum_s);
        end
        last = (k_r == (count_r - (WIDTH_ADDR_SIZE+1)'(1)));
    end

endmodule

// File: rtl/mat_stream_ctrl.sv
// Vector stream <-> matrix register sequencer (LOAD writes, STORE reads).
// Optional MAT_STREAM_TRANSPOSE_EN adds cmd_transpose and the XPOSE state.
module mat_stream_ctrl
    import MatPkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  MatStreamOp_t               cmd_op,
    input  logic [WIDTH_ADDR_SIZE-1:0] cmd_base,
    input  logic [WIDTH_ADDR_SIZE:0]   cmd_count,
`ifdef MAT_STREAM_TRANSPOSE_EN
    input  logic                       cmd_transpose,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  shortreal                   in_data [WIDTH],
    output logic                       out_valid,
    input  logic                       out_ready,
    output shortreal                   out_data [WIDTH],
    output MatDataWriteOp_t            mat_write_op,
    output logic [WIDTH_ADDR_SIZE-1:0] mat_write_param1,
    output logic [WIDTH_ADDR_SIZE-1:0] mat_write_param2,
    output shortreal                   mat_data_in [WIDTH],
    output MatDataReadOp_t             mat_read_op,
    output logic [WIDTH_ADDR_SIZE-1:0] mat_read_param,
    input  shortreal                   mat_data_out [WIDTH],
    output logic                       busy,
    output logic                       done
);
    localparam logic [WIDTH_ADDR_SIZE:0] WIDTH_W = (WIDTH_ADDR_SIZE+1)'(WIDTH);

    MatStreamState_t            state_r, state_next_s;
    MatStreamOp_t               op_r;
    logic                       accept_s;
    logic                       step_s;
    logic                       last_s;
    logic                       xpose_cmd_s;
    logic                       xpose_r;
    logic [WIDTH_ADDR_SIZE-1:0] idx_s;
    logic [WIDTH_ADDR_SIZE:0]   count_clamped_s;

    assign count_clamped_s = (cmd_count > WIDTH_W) ? WIDTH_W : cmd_count;
    assign mat_data_in     = in_data;
    assign out_data        = mat_data_out;

`ifdef MAT_STREAM_TRANSPOSE_EN
    assign xpose_cmd_s = cmd_transpose && is_load(cmd_op);
`else
    assign xpose_cmd_s = 1'b0;
`endif

    mat_stream_index_counter #(
        .WIDTH           (WIDTH),
        .WIDTH_ADDR_SIZE (WIDTH_ADDR_SIZE)
    ) u_index (
        .clock       (clock),
        .reset       (reset),
        .start       (accept_s),
        .start_base  (cmd_base),
        .start_count (count_clamped_s),
        .step        (step_s),
        .idx         (idx_s),
        .last        (last_s)
    );

    // State register and command latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= LOAD_ROWS;
            xpose_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                op_r    <= cmd_op;
                xpose_r <= xpose_cmd_s;
            end else begin
                op_r    <= op_r;
                xpose_r <= xpose_r;
            end
        end
    end

    // Next state and all register/stream controls.
    always_comb begin
        state_next_s     = state_r;
        accept_s         = 1'b0;
        step_s           = 1'b0;
        cmd_ready        = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        done             = 1'b0;
        busy             = (state_r != IDLE);
        mat_write_op     = MAT_DATA_WRITE_DISABLE;
        mat_write_param1 = '0;
        mat_write_param2 = '0;
        mat_read_op      = MAT_DATA_READ_ROW;
        mat_read_param   = '0;
        case (state_r)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    if (count_clamped_s == '0) begin
                        state_next_s = xpose_cmd_s ? XPOSE : DONE;
                    end else begin
                        state_next_s = is_load(cmd_op) ? LOAD : STORE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    step_s           = 1'b1;
                    mat_write_op     = (op_r == LOAD_ROWS) ? MAT_DATA_WRITE_ROW : MAT_DATA_WRITE_COL;
                    mat_write_param1 = idx_s;
                    if (last_s) begin
                        state_next_s = xpose_r ? XPOSE : DONE;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            STORE: begin
                out_valid      = 1'b1;
                mat_read_op    = (op_r == STORE_ROWS) ? MAT_DATA_READ_ROW : MAT_DATA_READ_COL;
                mat_read_param = idx_s;
                if (out_ready) begin
                    step_s       = 1'b1;
                    state_next_s = last_s ? DONE : STORE;
                end else begin
                    state_next_s = STORE;
                end
            end
            XPOSE: begin
                mat_write_op = MAT_DATA_WRITE_TRANSPOSE;
                state_next_s = DONE;
            end
            DONE: begin
                done         = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Directed bench for mat_stream_ctrl (WIDTH=4) with a behavioural matrix
// register attached; define MAT_STREAM_TRANSPOSE_EN to exercise XPOSE.
module tb_mat_stream_ctrl;
    import MatPkg::*;

    localparam int W  = 4;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    MatStreamOp_t  cmd_op = LOAD_ROWS;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_count = '0;
`ifdef MAT_STREAM_TRANSPOSE_EN
    logic          cmd_transpose = 1'b0;
`endif
    logic          in_valid = 1'b0;
    logic          in_ready;
    shortreal      in_data [W];
    logic          out_valid;
    logic          out_ready = 1'b0;
    shortreal      out_data [W];
    MatDataWriteOp_t mat_write_op;
    logic [AW-1:0] mat_write_param1, mat_write_param2;
    shortreal      mat_data_in [W];
    MatDataReadOp_t mat_read_op;
    logic [AW-1:0] mat_read_param;
    shortreal      mat_data_out [W];
    logic          busy, done;

    shortreal      mem [W][W];
    int            checks = 0;
    int            failures = 0;

    always #5 clock = ~clock;

    mat_stream_ctrl #(.WIDTH(W), .WIDTH_ADDR_SIZE(AW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
`ifdef MAT_STREAM_TRANSPOSE_EN
        .cmd_transpose(cmd_transpose),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mat_write_op(mat_write_op), .mat_write_param1(mat_write_param1),
        .mat_write_param2(mat_write_param2), .mat_data_in(mat_data_in),
        .mat_read_op(mat_read_op), .mat_read_param(mat_read_param),
        .mat_data_out(mat_data_out), .busy(busy), .done(done)
    );

    // Matrix register model: synchronous writes, combinational reads.
    always @(posedge clock) begin
        case (mat_write_op)
            MAT_DATA_WRITE_ROW:       for (int j = 0; j < W; j++) mem[mat_write_param1][j] <= mat_data_in[j];
            MAT_DATA_WRITE_COL:       for (int i = 0; i < W; i++) mem[i][mat_write_param1] <= mat_data_in[i];
            MAT_DATA_WRITE_TRANSPOSE: for (int i = 0; i < W; i++) for (int j = 0; j < W; j++) mem[i][j] <= mem[j][i];
            default: ;
        endcase
    end

    always_comb begin
        for (int j = 0; j < W; j++) begin
            mat_data_out[j] = (mat_read_op == MAT_DATA_READ_ROW) ? mem[mat_read_param][j] : mem[j][mat_read_param];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input shortreal obs, input shortreal exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0.1f expected=%0.1f", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input MatStreamOp_t op, input logic [AW-1:0] base,
                         input logic [AW:0] cnt, input logic xp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_count = cnt;
`ifdef MAT_STREAM_TRANSPOSE_EN
        cmd_transpose = xp;
`else
        if (xp) $display("note: transpose request ignored in this build");
`endif
        @(negedge clock);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int exp_col [5];
        logic exp_rdy [5];
        MatDataWriteOp_t exp_op [4];
        logic [AW-1:0] exp_par [4];
        for (int j = 0; j < W; j++) in_data[j] = 0.0;

        // Reset state
        cyc(); cyc();
        @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
        chk("rst_wr_p1", 32'(mat_write_param1), 32'd0);
        chk("rst_wr_p2", 32'(mat_write_param2), 32'd0);
        chk("rst_rd_op", 32'(mat_read_op), 32'(MAT_DATA_READ_ROW));
        chk("rst_rd_p", 32'(mat_read_param), 32'd0);
        reset = 1'b0;
        cyc();

        // LOAD_ROWS base=0 count=4, back-to-back rows
        issue(LOAD_ROWS, 2'd0, 3'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            for (int j = 0; j < W; j++) in_data[j] = shortreal'(10*i + j + 1);
            @(negedge clock);
            chk("ld_in_ready", 32'(in_ready), 32'd1);
            chk("ld_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_ROW));
            chk("ld_wr_p1", 32'(mat_write_param1), 32'(i));
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("ld_done_c5", 32'(done), 32'd1);
        chk("ld_done_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
        cyc();
        @(negedge clock);
        chk("ld_idle_done", 32'(done), 32'd0);
        chk("ld_idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                chk_r("ld_mem", mem[i][j], shortreal'(10*i + j + 1));
        cyc();

        // STORE_COLS base=2 count=3, out_ready 1,0,1,0,1
        exp_col = '{2, 3, 3, 0, 0};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        issue(STORE_COLS, 2'd2, 3'd3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            out_ready = exp_rdy[c];
            cmd_valid = (c == 1);
            @(negedge clock);
            chk("st_out_valid", 32'(out_valid), 32'd1);
            chk("st_rd_op", 32'(mat_read_op), 32'(MAT_DATA_READ_COL));
            chk("st_rd_p", 32'(mat_read_param), 32'(exp_col[c]));
            chk("st_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
            if (c == 1) chk("st_cmd_ready_busy", 32'(cmd_ready), 32'd0);
            for (int i = 0; i < W; i++)
                chk_r("st_out_data", out_data[i], shortreal'(10*i + exp_col[c] + 1));
            cyc();
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("st_done_c6", 32'(done), 32'd1);
        chk("st_done_out_valid", 32'(out_valid), 32'd0);
        cyc();

        // LOAD_ROWS count=0: done at cycle 1, no write
        issue(LOAD_ROWS, 2'd1, 3'd0, 1'b0);
        @(negedge clock);
        chk("z_done_c1", 32'(done), 32'd1);
        chk("z_in_ready", 32'(in_ready), 32'd0);
        chk("z_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
        cyc();

        // STORE_ROWS base=1 count=7 clamps to 4 beats: rows 1,2,3,0
        out_ready = 1'b1;
        issue(STORE_ROWS, 2'd1, 3'd7, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("cl_out_valid", 32'(out_valid), 32'd1);
            chk("cl_rd_p", 32'(mat_read_param), 32'((c + 1) % 4));
            chk_r("cl_out_data", out_data[0], shortreal'(10*((c + 1) % 4) + 1));
            cyc();
        end
        @(negedge clock);
        chk("cl_done_c5", 32'(done), 32'd1);
        chk("cl_out_valid_done", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        cyc();

        // LOAD_COLS base=3 count=2 with in_valid gaps 0,1,0,1
        exp_op  = '{MAT_DATA_WRITE_DISABLE, MAT_DATA_WRITE_COL, MAT_DATA_WRITE_DISABLE, MAT_DATA_WRITE_COL};
        exp_par = '{2'd0, 2'd3, 2'd0, 2'd0};
        issue(LOAD_COLS, 2'd3, 3'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            in_valid = c[0];
            for (int j = 0; j < W; j++) in_data[j] = shortreal'(((c < 2) ? 100 : 200) + j);
            @(negedge clock);
            chk("gap_wr_op", 32'(mat_write_op), 32'(exp_op[c]));
            chk("gap_wr_p1", 32'(mat_write_param1), 32'(exp_par[c]));
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("gap_done_c5", 32'(done), 32'd1);
        cyc();
        chk_r("gap_col3", mem[2][3], 102.0);
        chk_r("gap_col0", mem[1][0], 201.0);
        chk_r("gap_col1_kept", mem[1][1], 12.0);

        // Reset after two of four LOAD_ROWS beats
        issue(LOAD_ROWS, 2'd0, 3'd4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            for (int j = 0; j < W; j++) in_data[j] = shortreal'(500 + 10*i + j);
            cyc();
        end
        for (int j = 0; j < W; j++) in_data[j] = 999.0;
        reset = 1'b1;
        @(negedge clock);
        chk("rm_wr_op", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
        chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_in_ready", 32'(in_ready), 32'd0);
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        chk_r("rm_row0", mem[0][1], 501.0);
        chk_r("rm_row1", mem[1][2], 512.0);
        chk_r("rm_row2_kept", mem[2][1], 22.0);
        chk_r("rm_row3_kept", mem[3][2], 33.0);
        cyc();

`ifdef MAT_STREAM_TRANSPOSE_EN
        // LOAD_ROWS count=4 with transpose: XPOSE at cycle 5, done at 6
        issue(LOAD_ROWS, 2'd0, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            for (int j = 0; j < W; j++) in_data[j] = shortreal'(4*i + j);
            cyc();
        end
        in_valid = 1'b0;
        cmd_transpose = 1'b0;
        @(negedge clock);
        chk("xp_wr_op_c5", 32'(mat_write_op), 32'(MAT_DATA_WRITE_TRANSPOSE));
        chk("xp_done_c5", 32'(done), 32'd0);
        cyc();
        @(negedge clock);
        chk("xp_done_c6", 32'(done), 32'd1);
        chk("xp_wr_op_c6", 32'(mat_write_op), 32'(MAT_DATA_WRITE_DISABLE));
        chk_r("xp_m01", mem[0][1], 4.0);
        chk_r("xp_m30", mem[3][0], 3.0);
        chk_r("xp_m12", mem[1][2], 9.0);
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
